// File: rtl/switch_allocator_pkg.sv
// Shared NoC router types: port indices, port directions and the wormhole lock record.
package switch_allocator_pkg;
  localparam int NOC_PORTS = 5;
  localparam int NOC_VCS   = 4;
  localparam int NOC_PW    = $clog2(NOC_PORTS);
  localparam int NOC_VW    = $clog2(NOC_VCS);

  typedef logic [NOC_PW-1:0] port_idx_t;

  typedef enum logic [NOC_PW-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_dir_e;

  typedef struct packed {
    logic              valid;
    port_idx_t         in_port;
    logic [NOC_VW-1:0] vc;
  } lock_t;
endpackage

// File: rtl/switch_allocator_rr_arb_upd.sv
// Round-robin arbiter: combinational grant from the current pointer; the pointer
// moves past the winner only when the caller reports that the grant became final.
module rr_arb_upd #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] upd_i,
  output logic [N-1:0] gnt_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[IW'((int'(ptr_q) + i) % N)]) begin
        gnt_o[IW'((int'(ptr_q) + i) % N)] = 1'b1;
        found = 1'b1;
      end
    end
  end

  // upd_i is one-hot or zero; zero leaves the pointer frozen
  always_comb begin
    ptr_d = ptr_q;
    for (int j = 0; j < N; j++)
      if (upd_i[j]) ptr_d = IW'((j + 1) % N);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC pick, then per-output input pick,
// with ready gating, optional wormhole output locking and registered grants/crossbar selects.
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int PORT_NUM = NOC_PORTS,
  parameter int VC_NUM   = NOC_VCS,
  parameter bit HOLD_EN  = 1'b1,
  parameter int PW       = $clog2(PORT_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]         req_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]         tail_i,
  input  logic [PORT_NUM-1:0]                     out_ready_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]         grant_o,
  output logic [PORT_NUM-1:0]                     xbar_valid_o,
  output logic [PORT_NUM-1:0][PW-1:0]             xbar_sel_o,
  output logic [PORT_NUM-1:0]                     locked_o
);
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] port;
    logic [VW-1:0] vc;
  } lk_t;

  logic [PORT_NUM-1:0][VC_NUM-1:0]   elig, s1_gnt, grant_d, grant_q;
  logic [PORT_NUM-1:0][PW-1:0]       s1_op, xs_d, xs_q;
  logic [PORT_NUM-1:0][VW-1:0]       s1_vc;
  logic [PORT_NUM-1:0]               s1_vld, s1_tail, in_won, xv_d, xv_q;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_req, s2_gnt;   // [output][input]
  lk_t  [PORT_NUM-1:0]               lock_q;

  always_comb begin
    elig = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        if (req_i[p][v] && int'(out_port_i[p][v]) < PORT_NUM)
          if (out_ready_i[out_port_i[p][v]] &&
              (!lock_q[out_port_i[p][v]].vld ||
               (int'(lock_q[out_port_i[p][v]].port) == p &&
                int'(lock_q[out_port_i[p][v]].vc) == v)))
            elig[p][v] = 1'b1;
  end

  generate
    for (genvar p = 0; p < PORT_NUM; p++) begin : g_s1
      rr_arb_upd #(.N(VC_NUM)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (elig[p]),
        .upd_i (grant_d[p]),
        .gnt_o (s1_gnt[p])
      );
    end
  endgenerate

  always_comb begin
    s1_op   = '0;
    s1_vc   = '0;
    s1_vld  = '0;
    s1_tail = '0;
    s2_req  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      s1_vld[p]  = |s1_gnt[p];
      s1_tail[p] = |(s1_gnt[p] & tail_i[p]);
      for (int v = 0; v < VC_NUM; v++)
        if (s1_gnt[p][v]) begin
          s1_op[p] = out_port_i[p][v];
          s1_vc[p] = VW'(v);
        end
    end
    for (int o = 0; o < PORT_NUM; o++)
      for (int p = 0; p < PORT_NUM; p++)
        s2_req[o][p] = s1_vld[p] && int'(s1_op[p]) == o;
  end

  // Every stage-2 grant is final, so it doubles as the output pointer update
  generate
    for (genvar o = 0; o < PORT_NUM; o++) begin : g_s2
      rr_arb_upd #(.N(PORT_NUM)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (s2_req[o]),
        .upd_i (s2_gnt[o]),
        .gnt_o (s2_gnt[o])
      );
    end
  endgenerate

  always_comb begin
    in_won  = '0;
    xv_d    = '0;
    xs_d    = '0;
    grant_d = '0;
    for (int o = 0; o < PORT_NUM; o++)
      for (int p = 0; p < PORT_NUM; p++)
        if (s2_gnt[o][p]) begin
          in_won[p] = 1'b1;
          xv_d[o]   = 1'b1;
          xs_d[o]   = PW'(p);
        end
    for (int p = 0; p < PORT_NUM; p++)
      grant_d[p] = in_won[p] ? s1_gnt[p] : '0;
  end

  generate
    if (HOLD_EN) begin : g_lock
      lk_t [PORT_NUM-1:0] lock_d;

      // Head grants claim the output; the tail grant releases it on the same edge
      always_comb begin
        lock_d = lock_q;
        for (int o = 0; o < PORT_NUM; o++)
          if (xv_d[o]) begin
            if (s1_tail[xs_d[o]])
              lock_d[o] = '0;
            else if (!lock_q[o].vld)
              lock_d[o] = '{vld: 1'b1, port: xs_d[o], vc: s1_vc[xs_d[o]]};
          end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= '0;
        else        lock_q <= lock_d;
      end
    end else begin : g_nolock
      assign lock_q = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      xv_q    <= '0;
      xs_q    <= '0;
    end else begin
      grant_q <= grant_d;
      xv_q    <= xv_d;
      xs_q    <= xs_d;
    end
  end

  always_comb begin
    locked_o = '0;
    for (int o = 0; o < PORT_NUM; o++) locked_o[o] = lock_q[o].vld;
  end

  assign grant_o      = grant_q;
  assign xbar_valid_o = xv_q;
  assign xbar_sel_o   = xs_q;
endmodule
